// File: rtl/kamus_pkg.sv
// -----------------------------------------------------------------------------
// kamus_pkg
//   Shared types and constants for the kamus core pipeline.
//
//   stage_state_e : occupancy state of an inter-stage pipeline register.
//   NOP_INSTR     : RV32I canonical NOP (addi x0, x0, 0). It is used to build
//                   the bubble payload a stage drives while it holds nothing.
//   stage_count() : maps a stage state onto its occupancy count.
// -----------------------------------------------------------------------------
package kamus_pkg;

  typedef enum logic [1:0] {
    STG_EMPTY,
    STG_ONE,
    STG_FULL
  } stage_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Occupancy of a stage in each state: EMPTY=0, ONE=1, FULL=2.
  function automatic logic [1:0] stage_count(input stage_state_e s);
    case (s)
      STG_ONE:  return 2'd1;
      STG_FULL: return 2'd2;
      default:  return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/kamus_pipe_stage.sv
// -----------------------------------------------------------------------------
// kamus_pipe_stage
//   Reusable inter-stage pipeline register with a valid/ready handshake, an
//   optional two-entry skid buffer and a flush for branch/jump redirect.
//   When it holds nothing, the stage drives NOP_VALUE, so downstream decode
//   always sees a legal instruction.
//
// Parameters
//   DATA_WIDTH : payload width in bits.
//   SKID_EN    : 1 = two-entry skid buffer with a registered in_ready_o.
//                0 = single register with a combinational in_ready_o.
//   NOP_VALUE  : payload driven on out_data_o while out_valid_o = 0.
//
// Ports
//   clk_i        in   clock, rising edge
//   rst_i        in   synchronous, active-high reset
//   flush_i      in   drop all held entries and any same-cycle input
//   in_valid_i   in   upstream payload valid
//   in_ready_o   out  stage can accept a payload this cycle
//   in_data_i    in   upstream payload
//   out_valid_o  out  head entry valid
//   out_ready_i  in   downstream accepts the head entry
//   out_data_o   out  head payload, or NOP_VALUE when not valid
//   count_o      out  occupancy, 0..2 (0..1 when SKID_EN = 0)
// -----------------------------------------------------------------------------
module kamus_pipe_stage
  import kamus_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 64,
  parameter bit                    SKID_EN    = 1'b1,
  parameter logic [DATA_WIDTH-1:0] NOP_VALUE  = DATA_WIDTH'(NOP_INSTR)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic [1:0]            count_o
);

  stage_state_e          r_state;
  stage_state_e          w_state_next;
  logic [DATA_WIDTH-1:0] r_main;
  logic                  w_in_ready;
  logic                  w_out_valid;
  logic                  w_in_fire;
  logic                  w_out_fire;

  // A flushed input is never taken, even when the stage has room for it.
  assign w_in_fire  = in_valid_i & w_in_ready & ~flush_i;
  assign w_out_fire = w_out_valid & out_ready_i;

  // ---------------------------------------------------------------------------
  // State register (shared by both variants)
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so that every flop
  // samples the pre-edge values, whatever order the blocks run in.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= STG_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode (shared): the valid mask hides stale data in r_main.
  // ---------------------------------------------------------------------------
  assign w_out_valid = (r_state != STG_EMPTY);
  assign out_valid_o = w_out_valid;
  assign out_data_o  = w_out_valid ? r_main : NOP_VALUE;
  assign count_o     = stage_count(r_state);
  assign in_ready_o  = w_in_ready;

  generate
    if (SKID_EN) begin : gen_skid
      // -----------------------------------------------------------------------
      // Two-entry skid buffer. r_main is always the head and r_skid holds the
      // entry taken while the head was stalled. in_ready_o decodes only the
      // registered state, so no path runs from out_ready_i to in_ready_o.
      // -----------------------------------------------------------------------
      logic [DATA_WIDTH-1:0] r_skid;
      logic                  w_load_main_in;
      logic                  w_load_main_skid;
      logic                  w_load_skid;

      // Next-state logic, plus the data-path load strobes of each transition.
      // NOTE: every signal is given a default before the case statement, so a
      // path that leaves it unassigned cannot infer a latch.
      always_comb begin
        w_state_next     = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
          STG_EMPTY: begin
            if (w_in_fire) begin
              w_state_next   = STG_ONE;
              w_load_main_in = 1'b1;
            end
          end
          STG_ONE: begin
            if (w_in_fire && w_out_fire) begin
              w_load_main_in = 1'b1;
            end else if (w_in_fire) begin
              w_state_next = STG_FULL;
              w_load_skid  = 1'b1;
            end else if (w_out_fire) begin
              w_state_next = STG_EMPTY;
            end
          end
          STG_FULL: begin
            // in_ready is low here. The input is taken next cycle, from ONE.
            if (w_out_fire) begin
              w_state_next     = STG_ONE;
              w_load_main_skid = 1'b1;
            end
          end
          default: begin
            w_state_next = STG_EMPTY;
          end
        endcase
        // A redirect overrides every transfer of this cycle.
        if (flush_i) begin
          w_state_next = STG_EMPTY;
        end
      end

      // Ready decode from the registered state only.
      always_comb begin
        w_in_ready = (r_state != STG_FULL) & ~rst_i;
      end

      // NOTE: payload registers have no reset. Only the state is reset, and
      // the valid decode masks out whatever the data flops hold.
      always_ff @(posedge clk_i) begin
        if (w_load_main_in) begin
          r_main <= in_data_i;
        end else if (w_load_main_skid) begin
          r_main <= r_skid;
        end
        if (w_load_skid) begin
          r_skid <= in_data_i;
        end
      end

    end else begin : gen_single
      // -----------------------------------------------------------------------
      // Single register. Ready is combinational: the stage can take a new
      // payload whenever the head leaves in the same cycle.
      // -----------------------------------------------------------------------
      always_comb begin
        w_state_next = r_state;
        if (w_in_fire) begin
          w_state_next = STG_ONE;
        end else if (w_out_fire) begin
          w_state_next = STG_EMPTY;
        end
        if (flush_i) begin
          w_state_next = STG_EMPTY;
        end
      end

      always_comb begin
        w_in_ready = (~w_out_valid | out_ready_i) & ~rst_i;
      end

      always_ff @(posedge clk_i) begin
        if (w_in_fire) begin
          r_main <= in_data_i;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_kamus_pipe_stage.sv
// -----------------------------------------------------------------------------
// tb_kamus_pipe_stage
//   Directed and random checks of kamus_pipe_stage. Instance dut_a has the skid
//   buffer (SKID_EN=1). Instance dut_b is the single-register variant
//   (SKID_EN=0). Both instances share clock, reset and flush.
// -----------------------------------------------------------------------------
module tb_kamus_pipe_stage;
  import kamus_pkg::*;

  localparam int unsigned   DW  = 64;
  localparam logic [DW-1:0] NOP = {32'h0, NOP_INSTR};

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;

  logic          a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [DW-1:0] a_in_data, a_out_data;
  logic [1:0]    a_count;

  logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [DW-1:0] b_in_data, b_out_data;
  logic [1:0]    b_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  kamus_pipe_stage #(.DATA_WIDTH(DW), .SKID_EN(1'b1), .NOP_VALUE(NOP)) dut_a (
    .clk_i      (clk),
    .rst_i      (rst),
    .flush_i    (flush),
    .in_valid_i (a_in_valid),
    .in_ready_o (a_in_ready),
    .in_data_i  (a_in_data),
    .out_valid_o(a_out_valid),
    .out_ready_i(a_out_ready),
    .out_data_o (a_out_data),
    .count_o    (a_count)
  );

  kamus_pipe_stage #(.DATA_WIDTH(DW), .SKID_EN(1'b0), .NOP_VALUE(NOP)) dut_b (
    .clk_i      (clk),
    .rst_i      (rst),
    .flush_i    (flush),
    .in_valid_i (b_in_valid),
    .in_ready_o (b_in_ready),
    .in_data_i  (b_in_data),
    .out_valid_o(b_out_valid),
    .out_ready_i(b_out_ready),
    .out_data_o (b_out_data),
    .count_o    (b_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge and checks follow
  // 1 unit later, so sampling stays well away from the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Safety net: the run must never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] qa[$];
    logic [63:0] qb[$];
    logic        a_rdy, b_rdy, a_acc, b_acc, a_hold, b_hold;
    logic [63:0] exp_head;
    logic        acc;

    rst = 1'b1; flush = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;

    // ---------------- reset ----------------
    tick();
    check("rst_a_in_ready_low", a_in_ready, 1'b0);
    check("rst_b_in_ready_low", b_in_ready, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    check("rst_a_in_ready", a_in_ready, 1'b1);
    check("rst_a_out_valid", a_out_valid, 1'b0);
    check("rst_a_out_data", a_out_data, NOP);
    check("rst_a_count", a_count, 2'd0);
    check("rst_b_out_valid", b_out_valid, 1'b0);
    check("rst_b_count", b_count, 2'd0);

    // ---------------- streaming ----------------
    a_out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = 64'(i);
      tick();
      check("stream_valid", a_out_valid, 1'b1);
      check("stream_data", a_out_data, 64'(i));
      check("stream_count", a_count, 2'd1);
      check("stream_ready", a_in_ready, 1'b1);
    end
    a_in_valid = 1'b0;
    tick();
    check("stream_drain_valid", a_out_valid, 1'b0);
    check("stream_drain_data", a_out_data, NOP);

    // ---------------- stall fill ----------------
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 64'hA;
    tick();
    check("stall_one_head", a_out_data, 64'hA);
    a_in_data = 64'hB;
    tick();
    check("stall_full_count", a_count, 2'd2);
    check("stall_full_ready", a_in_ready, 1'b0);
    check("stall_full_head", a_out_data, 64'hA);
    a_in_data = 64'hC;
    tick();
    check("stall_hold_count", a_count, 2'd2);
    check("stall_hold_head", a_out_data, 64'hA);
    a_out_ready = 1'b1;
    #1;
    check("stall_rel_head_a", a_out_data, 64'hA);
    tick();
    check("stall_rel_head_b", a_out_data, 64'hB);
    check("stall_rel_count_b", a_count, 2'd1);
    check("stall_rel_ready", a_in_ready, 1'b1);
    tick();
    check("stall_rel_head_c", a_out_data, 64'hC);
    check("stall_rel_valid_c", a_out_valid, 1'b1);
    a_in_valid = 1'b0;
    tick();
    check("stall_rel_empty", a_out_valid, 1'b0);

    // ---------------- flush ----------------
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 64'hA;
    tick();
    a_in_data = 64'hB;
    tick();
    check("flush_pre_count", a_count, 2'd2);
    a_in_data = 64'hC; flush = 1'b1;
    tick();
    flush = 1'b0; a_in_valid = 1'b0;
    #1;
    check("flush_valid", a_out_valid, 1'b0);
    check("flush_data", a_out_data, NOP);
    check("flush_count", a_count, 2'd0);
    check("flush_ready", a_in_ready, 1'b1);
    a_out_ready = 1'b1;
    tick();
    check("flush_no_c", a_out_valid, 1'b0);
    // Flush while ONE, where the stage would otherwise take the input.
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 64'hD;
    tick();
    check("flush1_head_d", a_out_data, 64'hD);
    a_in_data = 64'hE; flush = 1'b1;
    tick();
    flush = 1'b0; a_in_valid = 1'b0;
    #1;
    check("flush1_valid", a_out_valid, 1'b0);
    check("flush1_count", a_count, 2'd0);

    // ---------------- reset mid-stream ----------------
    a_in_valid = 1'b1; a_in_data = 64'h5;
    tick();
    a_in_valid = 1'b0;
    check("rstmid_head", a_out_data, 64'h5);
    rst = 1'b1;
    #1;
    check("rstmid_ready_low", a_in_ready, 1'b0);
    tick();
    check("rstmid_valid", a_out_valid, 1'b0);
    check("rstmid_count", a_count, 2'd0);
    check("rstmid_data", a_out_data, NOP);
    rst = 1'b0;
    #1;
    check("rstmid_ready_high", a_in_ready, 1'b1);

    // ---------------- SKID_EN=0, toggling ready ----------------
    b_in_valid = 1'b1;
    b_in_data  = 64'h21;
    exp_head   = '0;
    for (int c = 0; c < 8; c++) begin
      b_out_ready = (c % 2 == 0);
      #1;
      check("single_ready", b_in_ready, (c == 0) ? 1'b1 : b_out_ready);
      check("single_count", b_count, (c == 0) ? 2'd0 : 2'd1);
      if (c > 0) check("single_head", b_out_data, exp_head);
      acc = (c == 0) || b_out_ready;
      tick();
      if (acc) begin
        exp_head  = b_in_data;
        b_in_data = b_in_data + 64'd1;
      end
    end
    b_in_valid = 1'b0; b_out_ready = 1'b1;
    tick();
    check("single_drain", b_out_valid, 1'b0);

    // ---------------- random with scoreboards ----------------
    qa.delete(); qb.delete();
    a_hold = 1'b0; b_hold = 1'b0;
    a_in_valid = 1'b0; b_in_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      // Upstream keeps a payload steady until it is taken.
      if (!a_hold) begin
        a_in_valid = 1'($urandom_range(0, 1));
        a_in_data  = {$urandom, $urandom};
      end
      if (!b_hold) begin
        b_in_valid = 1'($urandom_range(0, 1));
        b_in_data  = {$urandom, $urandom};
      end
      a_out_ready = 1'($urandom_range(0, 1));
      b_out_ready = 1'($urandom_range(0, 1));
      flush       = ($urandom_range(0, 99) < 5);
      #1;
      a_rdy = (qa.size() < 2);
      b_rdy = (qb.size() == 0) || b_out_ready;
      check("rnd_a_ready", a_in_ready, a_rdy);
      check("rnd_a_valid", a_out_valid, qa.size() != 0);
      check("rnd_a_data", a_out_data, (qa.size() != 0) ? qa[0] : NOP);
      check("rnd_a_count", a_count, 64'(qa.size()));
      check("rnd_b_ready", b_in_ready, b_rdy);
      check("rnd_b_valid", b_out_valid, qb.size() != 0);
      check("rnd_b_data", b_out_data, (qb.size() != 0) ? qb[0] : NOP);
      check("rnd_b_count", b_count, 64'(qb.size()));
      a_acc = a_in_valid && a_rdy && !flush;
      b_acc = b_in_valid && b_rdy && !flush;
      if (flush) begin
        qa.delete();
        qb.delete();
      end else begin
        if (qa.size() != 0 && a_out_ready) void'(qa.pop_front());
        if (a_acc) qa.push_back(a_in_data);
        if (qb.size() != 0 && b_out_ready) void'(qb.pop_front());
        if (b_acc) qb.push_back(b_in_data);
      end
      a_hold = a_in_valid && !a_acc;
      b_hold = b_in_valid && !b_acc;
      tick();
    end
    flush = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
